// File: rtl/common.sv
// Shared definitions for the memory port arbiter: operand width, FSM states and grant indices.
package common;

    localparam int unsigned OPERAND_WIDTH = 32;
    localparam int unsigned CNT_WIDTH     = 8;

    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_LS = 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

endpackage

// File: rtl/mem_arb_select.sv
// Two-requester winner selection; the pointed-to requester wins when both ask.
module mem_arb_select
    import common::*;
(
    input  logic       if_req,
    input  logic       ls_req,
    input  logic       ptr_ls,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (ls_req && (ptr_ls || !if_req)) begin
            grant[GNT_LS] = 1'b1;
        end else if (if_req) begin
            grant[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch and load/store, one access outstanding.
// Define MEM_ARB_RR_EN for round-robin; otherwise load/store has fixed priority.
module mem_port_arbiter
    import common::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [OPERAND_WIDTH-1:0] if_addr,
    output logic                     if_done,
    output logic [31:0]              if_rdata,
    input  logic                     ls_req,
    input  logic                     ls_we,
    input  logic [OPERAND_WIDTH-1:0] ls_addr,
    input  logic [OPERAND_WIDTH-1:0] ls_wdata,
    output logic                     ls_done,
    output logic [31:0]              ls_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [OPERAND_WIDTH-1:0] mem_addr,
    output logic [OPERAND_WIDTH-1:0] mem_wdata,
    input  logic                     mem_ready,
    input  logic [31:0]              mem_rdata,
    output logic                     bus_err
);

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [OPERAND_WIDTH-1:0] addr_q, addr_d;
    logic [OPERAND_WIDTH-1:0] wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic                     win_ls_q, win_ls_d;
    logic                     if_done_q, if_done_d;
    logic                     ls_done_q, ls_done_d;
    logic                     bus_err_q, bus_err_d;
    logic [31:0]              if_rdata_q, if_rdata_d;
    logic [31:0]              ls_rdata_q, ls_rdata_d;
    logic                     ptr_ls;
    logic                     grant_en;
    logic [1:0]               grant;

    mem_arb_select u_select (
        .if_req (if_req),
        .ls_req (ls_req),
        .ptr_ls (ptr_ls),
        .grant  (grant)
    );

`ifdef MEM_ARB_RR_EN
    logic ptr_ls_q, ptr_ls_d;

    assign ptr_ls = ptr_ls_q;

    // Point at whichever requester did not just win.
    always_comb begin
        ptr_ls_d = ptr_ls_q;
        if (grant_en) begin
            ptr_ls_d = grant[GNT_IF];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_ls_q <= 1'b1;
        end else begin
            ptr_ls_q <= ptr_ls_d;
        end
    end
`else
    assign ptr_ls = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        win_ls_d   = win_ls_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        bus_err_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        grant_en   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                // No grant during a done pulse: the finishing requester still holds req.
                if ((if_req || ls_req) && !if_done_q && !ls_done_q) begin
                    grant_en = 1'b1;
                    state_d  = ARB_BUSY;
                    cnt_d    = '0;
                    win_ls_d = grant[GNT_LS];
                    addr_d   = grant[GNT_IF] ? if_addr : ls_addr;
                    we_d     = grant[GNT_LS] & ls_we;
                    wdata_d  = grant[GNT_LS] ? ls_wdata : '0;
                end
            end
            ARB_BUSY: begin
                if (mem_ready || cnt_q == CntLast) begin
                    state_d   = ARB_IDLE;
                    bus_err_d = !mem_ready;
                    if (win_ls_q) begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                end
                if (!mem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            win_ls_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            win_ls_q   <= win_ls_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            bus_err_q  <= bus_err_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_req   = (state_q == ARB_BUSY);
    assign mem_we    = (state_q == ARB_BUSY) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (built with TIMEOUT_CYCLES = 4).
module tb_mem_port_arbiter;
    import common::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     if_req = 1'b0;
    logic [OPERAND_WIDTH-1:0] if_addr = '0;
    logic                     if_done;
    logic [31:0]              if_rdata;
    logic                     ls_req = 1'b0;
    logic                     ls_we = 1'b0;
    logic [OPERAND_WIDTH-1:0] ls_addr = '0;
    logic [OPERAND_WIDTH-1:0] ls_wdata = '0;
    logic                     ls_done;
    logic [31:0]              ls_rdata;
    logic                     mem_req;
    logic                     mem_we;
    logic [OPERAND_WIDTH-1:0] mem_addr;
    logic [OPERAND_WIDTH-1:0] mem_wdata;
    logic                     mem_ready = 1'b0;
    logic [31:0]              mem_rdata = '0;
    logic                     bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, if_done, ls_done, bus_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_done, ls_done, bus_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, ls_rdata});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req  = 1'b1;
        if_addr = 32'h40;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, if_done} !== {2'b10, 32'h40, 1'b0}) begin
            errors++;
            $display("FAIL fetch_req: got req=%b we=%b addr=%h done=%b want 1 0 00000040 0",
                     mem_req, mem_we, mem_addr, if_done);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h00A00093;
        tick();
        checks++;
        if ({if_done, ls_done, mem_req, if_rdata} !== {3'b100, 32'h00A00093}) begin
            errors++;
            $display("FAIL fetch_done: got done=%b ls_done=%b req=%b rdata=%h want 1 0 0 00a00093",
                     if_done, ls_done, mem_req, if_rdata);
        end
        if_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        checks++;
        if ({if_done, if_rdata} !== {1'b0, 32'h00A00093}) begin
            errors++;
            $display("FAIL fetch_hold: got done=%b rdata=%h want 0 00a00093", if_done, if_rdata);
        end
    endtask

    task automatic test_store();
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h100;
        ls_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, ls_done} !== {2'b11, 32'h100, 32'hDEADBEEF, 1'b0}) begin
                errors++;
                $display("FAIL store_busy%0d: got req=%b we=%b addr=%h wdata=%h done=%b want 1 1 00000100 deadbeef 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, ls_done);
            end
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0;
        tick();
        checks++;
        if ({ls_done, if_done, mem_req, bus_err} !== 4'b1000) begin
            errors++;
            $display("FAIL store_done: got ls_done=%b if_done=%b req=%b err=%b want 1 0 0 0",
                     ls_done, if_done, mem_req, bus_err);
        end
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        mem_ready = 1'b0;
        tick();
        checks++;
        if ({ls_done, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL store_pulse: got ls_done=%b we=%b want 0 0", ls_done, mem_we);
        end
    endtask

    task automatic test_load_drop();
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h104;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h104}) begin
            errors++;
            $display("FAIL load_req: got req=%b we=%b addr=%h want 1 0 00000104", mem_req, mem_we, mem_addr);
        end
        ls_req = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL load_dropreq: got mem_req=%b want 1", mem_req);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        checks++;
        if ({ls_done, ls_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL load_done: got done=%b rdata=%h want 1 cafef00d", ls_done, ls_rdata);
        end
        mem_ready = 1'b0;
        tick();
        checks++;
        if ({ls_done, ls_rdata} !== {1'b0, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL load_hold: got done=%b rdata=%h want 0 cafef00d", ls_done, ls_rdata);
        end
    endtask

    task automatic test_arbitration();
        logic [2:0] seen_ls;
        logic [2:0] want_ls;
        int         n = 0;
        int         errs_seen = 0;
`ifdef MEM_ARB_RR_EN
        want_ls = 3'b101;
`else
        want_ls = 3'b111;
`endif
        seen_ls   = '0;
        if_req    = 1'b1;
        if_addr   = 32'h200;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_addr   = 32'h300;
        mem_ready = 1'b1;
        mem_rdata = 32'h11110000;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            tick();
            if (bus_err) errs_seen++;
            if (ls_done || if_done) begin
                seen_ls[n] = ls_done;
                n++;
            end
        end
        if_req    = 1'b0;
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL arb_count: got %0d completions want 3", n);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seen_ls[k] !== want_ls[k]) begin
                errors++;
                $display("FAIL arb_grant%0d: got ls=%b want ls=%b", k, seen_ls[k], want_ls[k]);
            end
        end
        checks++;
        if (errs_seen !== 0) begin
            errors++;
            $display("FAIL arb_buserr: got %0d bus_err pulses want 0", errs_seen);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        if_req    = 1'b1;
        if_addr   = 32'h80;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({mem_req, bus_err, if_done} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_busy%0d: got req=%b err=%b done=%b want 1 0 0",
                         i, mem_req, bus_err, if_done);
            end
        end
        tick();
        checks++;
        if ({bus_err, if_done, mem_req, if_rdata} !== {3'b110, 32'h0}) begin
            errors++;
            $display("FAIL timeout_abort: got err=%b done=%b req=%b rdata=%h want 1 1 0 00000000",
                     bus_err, if_done, mem_req, if_rdata);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if ({bus_err, if_done, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_idle: got err=%b done=%b req=%b want 0 0 0", bus_err, if_done, mem_req);
        end
    endtask

    task automatic test_reset_busy();
        ls_req  = 1'b1;
        ls_we   = 1'b1;
        ls_addr = 32'h400;
        ls_wdata = 32'h55AA55AA;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstbusy_pre: got mem_req=%b want 1", mem_req);
        end
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
        checks++;
        if ({mem_req, mem_we, if_done, ls_done, bus_err} !== 5'b0) begin
            errors++;
            $display("FAIL rstbusy_ctrl: got %b want 00000", {mem_req, mem_we, if_done, ls_done, bus_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL rstbusy_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, ls_rdata});
        end
        tick();
        checks++;
        if ({mem_req, ls_done, bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL rstbusy_after: got req=%b done=%b err=%b want 0 0 0", mem_req, ls_done, bus_err);
        end
    endtask

    task automatic test_idle_ready();
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mem_req, if_done, ls_done, bus_err, if_rdata, ls_rdata} !== {4'b0, 64'h0}) begin
                errors++;
                $display("FAIL idle_ready%0d: got req=%b done=%b%b err=%b rdata=%h/%h want all 0",
                         i, mem_req, if_done, ls_done, bus_err, if_rdata, ls_rdata);
            end
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load_drop();
        test_arbitration();
        test_timeout();
        test_reset_busy();
        test_idle_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
